// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
//   state_t : loader FSM states (LEN, DATA, SUM, ACK, DONE, ERR)
//   ACK_OK  : acknowledge byte sent to the host on a successful load
//   ACK_ERR : acknowledge byte sent to the host on a rejected load
package loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN,
        ST_DATA,
        ST_SUM,
        ST_ACK,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [7:0] ACK_OK  = 8'hAA;
    localparam logic [7:0] ACK_ERR = 8'hEE;

endpackage

// File: rtl/byte_assembler.sv
// Packs a stream of bytes into little-endian 32-bit words.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   byte_valid   : a byte is accepted this cycle
//   byte_data    : the accepted byte
//   word         : assembled word; valid only while word_valid is high
//   word_valid   : high in the cycle the 4th byte of a word is accepted
// The first byte lands in bits [7:0]. The word is presented combinationally
// with the 4th byte so the parent can register it in the same cycle.
module byte_assembler (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  byte_cnt;
    logic [23:0] shift;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt <= 2'd0;
            shift    <= 24'd0;
        end else if (byte_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            // Shift right so the oldest byte ends up in the low bits.
            shift    <= {byte_data, shift[23:8]};
        end
    end

    assign word_valid = byte_valid && (byte_cnt == 2'd3);
    assign word       = {byte_data, shift};

endmodule

// File: rtl/program_loader.sv
// Boot-time writer for the CPU instruction memory.
// Receives a word count N and N little-endian words from the UART receiver,
// writes them to consecutive word addresses, then sends one acknowledge byte
// (0xAA success / 0xEE error) and raises the sticky load_done or load_error.
// Ports:
//   clk, reset_n          : system clock, asynchronous active-low reset
//   rx_valid/rx_data      : received byte in, rx_ready = accepted
//   tx_valid/tx_data      : acknowledge byte out, tx_ready = taken
//   mem_we/addr/wdata     : registered single-cycle instruction-memory write
//   load_done/load_error  : sticky completion status until reset
// Build option: define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte over all data bytes.
//
// state | meaning
// LEN   | collecting the 4-byte word count
// DATA  | collecting words, one memory write per word
// SUM   | waiting for the checksum byte (checksum build only)
// ACK   | presenting the acknowledge byte
// DONE  | load succeeded, idle until reset
// ERR   | load rejected, idle until reset
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              load_done,
    output logic              load_error
);

    // One extra bit over the word index so N == MAX_WORDS does not wrap.
    localparam int          CW        = ADDR_W - 1;
    localparam logic [31:0] MAX_WORDS = 32'd1 << (ADDR_W - 2);

    state_t        state;
    logic [CW-1:0] word_idx;
    logic [CW-1:0] last_idx;
    logic          err;
    logic          take;
    logic          asm_valid;
    logic [31:0]   asm_word;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]    xor_acc;
`endif

    assign take = rx_valid && rx_ready && (state == ST_LEN || state == ST_DATA);

    byte_assembler u_asm (
        .clk        (clk),
        .reset_n    (reset_n),
        .byte_valid (take),
        .byte_data  (rx_data),
        .word       (asm_word),
        .word_valid (asm_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_LEN;
            word_idx   <= '0;
            last_idx   <= '0;
            err        <= 1'b0;
            rx_ready   <= 1'b0;
            tx_valid   <= 1'b0;
            tx_data    <= 8'd0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            xor_acc    <= 8'd0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                ST_LEN: begin
                    rx_ready <= 1'b1;
                    if (asm_valid) begin
                        if (asm_word > MAX_WORDS) begin
                            err      <= 1'b1;
                            rx_ready <= 1'b0;
                            state    <= ST_ACK;
                        end else if (asm_word == 32'd0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            state    <= ST_SUM;
`else
                            rx_ready <= 1'b0;
                            state    <= ST_ACK;
`endif
                        end else begin
                            last_idx <= CW'(asm_word - 32'd1);
                            word_idx <= '0;
                            state    <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    if (take) xor_acc <= xor_acc ^ rx_data;
`endif
                    if (asm_valid) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= {word_idx[ADDR_W-3:0], 2'b00};
                        mem_wdata <= asm_word;
                        word_idx  <= word_idx + CW'(1);
                        if (word_idx == last_idx) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            state    <= ST_SUM;
`else
                            rx_ready <= 1'b0;
                            state    <= ST_ACK;
`endif
                        end
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                ST_SUM: begin
                    if (rx_valid && rx_ready) begin
                        err      <= (rx_data != xor_acc);
                        rx_ready <= 1'b0;
                        state    <= ST_ACK;
                    end
                end
`endif
                ST_ACK: begin
                    // tx_valid rises one cycle after entry, so the last
                    // memory write always precedes the acknowledge.
                    rx_ready <= 1'b0;
                    tx_valid <= 1'b1;
                    tx_data  <= err ? ACK_ERR : ACK_OK;
                    if (tx_valid && tx_ready) begin
                        tx_valid   <= 1'b0;
                        tx_data    <= 8'd0;
                        load_done  <= !err;
                        load_error <= err;
                        state      <= err ? ST_ERR : ST_DONE;
                    end
                end
                ST_DONE, ST_ERR: begin
                    rx_ready <= 1'b0;
                end
                default: begin
                    rx_ready <= 1'b0;
                    state    <= ST_ACK;
                end
            endcase
        end
    end

endmodule
